// File: rtl/regfile_mp_if.sv
// regfile_mp_if: write, read and clear signals of the two-write/two-read register file.
// master drives writes, read addresses and clear requests. slave is the register file.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              clr_req;
    logic              ready;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic [ADDR_W-1:0] ra_a;
    logic [ADDR_W-1:0] ra_b;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    modport master (
        output clr_req, we0, wa0, wd0, we1, wa1, wd1, ra_a, ra_b,
        input  ready, rd_a, rd_b
    );

    modport slave (
        input  clr_req, we0, wa0, wd0, we1, wa1, wd1, ra_a, ra_b,
        output ready, rd_a, rd_b
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised 2-write / 2-read register file with registered reads,
// optional hardwired-zero entry 0 and a sequential clear engine.
// When both write ports hit the same address, port 1 wins.
// The clear engine zeroes one entry per cycle after reset or on clr_req.
// Optional macro REGFILE_BYPASS_EN: a read returns the data of a same-cycle write to its address.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    regfile_mp_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e            state_q,   state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              ready_q,   ready_d;
    logic [DATA_W-1:0] rd_a_q,    rd_a_d;
    logic [DATA_W-1:0] rd_b_q,    rd_b_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    // State, outputs and array; the synchronous reset is folded into the next-state logic
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        ready_q   <= ready_d;
        rd_a_q    <= rd_a_d;
        rd_b_q    <= rd_b_d;
        mem_q     <= mem_d;
    end

    // Next state: reset, clear sweep, or run-mode writes/reads/clear request
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        rd_a_d    = '0;
        rd_b_d    = '0;
        mem_d     = mem_q;

        if (rst) begin
            // reset restarts the clear but leaves the array untouched
            state_d   = CLEAR;
            clr_idx_d = '0;
            ready_d   = 1'b0;
        end else begin
            unique case (state_q)
                CLEAR: begin
                    mem_d[clr_idx_q] = '0;
                    clr_idx_d        = clr_idx_q + ADDR_W'(1);
                    if (clr_idx_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end
                end
                RUN: begin
                    // reads see the array before this edge's writes
                    rd_a_d = mem_q[bus.ra_a];
                    rd_b_d = mem_q[bus.ra_b];
`ifdef REGFILE_BYPASS_EN
                    // later assignment wins: port 1 has priority over port 0
                    if (bus.we0 && bus.wa0 == bus.ra_a) rd_a_d = bus.wd0;
                    if (bus.we1 && bus.wa1 == bus.ra_a) rd_a_d = bus.wd1;
                    if (bus.we0 && bus.wa0 == bus.ra_b) rd_b_d = bus.wd0;
                    if (bus.we1 && bus.wa1 == bus.ra_b) rd_b_d = bus.wd1;
`endif
                    if (ZERO_REG != 0 && bus.ra_a == '0) rd_a_d = '0;
                    if (ZERO_REG != 0 && bus.ra_b == '0) rd_b_d = '0;

                    // port 1 is applied last so it wins an address collision
                    if (bus.we0 && !(ZERO_REG != 0 && bus.wa0 == '0)) mem_d[bus.wa0] = bus.wd0;
                    if (bus.we1 && !(ZERO_REG != 0 && bus.wa1 == '0)) mem_d[bus.wa1] = bus.wd1;

                    if (bus.clr_req) begin
                        state_d   = CLEAR;
                        clr_idx_d = '0;
                        ready_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = CLEAR;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.rd_a  = rd_a_q;
    assign bus.rd_b  = rd_b_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for regfile_mp. A driver issues one operation per
// cycle and pushes the reference model's expected outputs into a queue. A monitor
// pops one entry after each rising edge and compares it with the DUT outputs.
module tb_regfile_mp;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned ZERO_REG = 1;
    localparam int unsigned DEPTH    = 1 << ADDR_W;

    typedef struct {
        logic [DATA_W-1:0] rd_a;
        logic [DATA_W-1:0] rd_b;
        logic              ready;
        int                id;
    } exp_t;

    logic clk;
    logic rst;
    regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;

    // Reference model: the array is busy for DEPTH edges after a clear starts
    // (reset or clr_req) and is entirely zero afterwards.
    logic [DATA_W-1:0] m_mem [DEPTH];
    bit                m_busy = 1'b1;
    int                m_left = 0;

    function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] ra,
                                                 input logic w0, input logic [ADDR_W-1:0] a0,
                                                 input logic [DATA_W-1:0] d0,
                                                 input logic w1, input logic [ADDR_W-1:0] a1,
                                                 input logic [DATA_W-1:0] d1);
        logic [DATA_W-1:0] v;
        v = m_mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (w0 && a0 == ra) v = d0;
        if (w1 && a1 == ra) v = d1;
`else
        if (w0 && w1 && a0 == a1 && d0 == d1) v = m_mem[ra];
`endif
        if (ZERO_REG != 0 && ra == '0) v = '0;
        return v;
    endfunction

    // One clock edge of stimulus: drive inputs, advance the model, queue expectations
    task automatic step(input logic r, input logic c,
                        input logic w0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                        input logic w1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                        input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        exp_t e;
        @(negedge clk);
        rst         = r;
        bus.clr_req = c;
        bus.we0 = w0; bus.wa0 = a0; bus.wd0 = d0;
        bus.we1 = w1; bus.wa1 = a1; bus.wd1 = d1;
        bus.ra_a = ra; bus.ra_b = rb;

        e.rd_a = '0;
        e.rd_b = '0;
        if (r) begin
            m_busy = 1'b1;
            m_left = DEPTH;
        end else if (m_busy) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
            end
        end else begin
            e.rd_a = m_read(ra, w0, a0, d0, w1, a1, d1);
            e.rd_b = m_read(rb, w0, a0, d0, w1, a1, d1);
            if (w0 && !(ZERO_REG != 0 && a0 == '0)) m_mem[a0] = d0;
            if (w1 && !(ZERO_REG != 0 && a1 == '0)) m_mem[a1] = d1;
            if (c) begin
                m_busy = 1'b1;
                m_left = DEPTH;
            end
        end
        e.ready = !m_busy;
        e.id    = step_id;
        step_id++;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb);
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ra, rb);
    endtask

    // Monitor: one expectation is consumed per rising edge once stimulus has started
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.ready !== e.ready) begin
                    errors++;
                    $display("FAIL ready step=%0d got=%0b exp=%0b", e.id, bus.ready, e.ready);
                end
                checks++;
                if (bus.rd_a !== e.rd_a) begin
                    errors++;
                    $display("FAIL rd_a step=%0d ra_a=%0d got=%h exp=%h", e.id, bus.ra_a, bus.rd_a, e.rd_a);
                end
                checks++;
                if (bus.rd_b !== e.rd_b) begin
                    errors++;
                    $display("FAIL rd_b step=%0d ra_b=%0d got=%h exp=%h", e.id, bus.ra_b, bus.rd_b, e.rd_b);
                end
            end
        end
    end

    // Driver: directed cases from the test plan, then randomized traffic
    initial begin
        logic [ADDR_W-1:0] a0, a1, ra, rb;
        rst = 1'b1;
        bus.clr_req = 1'b0;
        bus.we0 = 1'b0; bus.wa0 = '0; bus.wd0 = '0;
        bus.we1 = 1'b0; bus.wa1 = '0; bus.wd1 = '0;
        bus.ra_a = '0; bus.ra_b = '0;

        // reset for two cycles, then the clear sweep with writes that must be ignored
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 1'b1, ADDR_W'(i), 32'hDEAD0000, 1'b1, ADDR_W'(DEPTH-1-i), 32'h0000BEEF,
                 ADDR_W'(i), ADDR_W'(i + 1));
        for (int i = 0; i < DEPTH; i++) idle(ADDR_W'(i), ADDR_W'(DEPTH-1-i));

        // dual write, then read back
        step(1'b0, 1'b0, 1'b1, ADDR_W'(3), 32'h11111111, 1'b1, ADDR_W'(7), 32'h22222222, '0, '0);
        idle(ADDR_W'(3), ADDR_W'(7));

        // collision on address 5
        step(1'b0, 1'b0, 1'b1, ADDR_W'(5), 32'hAAAA0000, 1'b1, ADDR_W'(5), 32'h0000BBBB, '0, '0);
        idle(ADDR_W'(5), ADDR_W'(3));

        // both ports write all-ones to address 0
        step(1'b0, 1'b0, 1'b1, '0, 32'hFFFFFFFF, 1'b1, '0, 32'hFFFFFFFF, '0, '0);
        idle('0, ADDR_W'(7));

        // same-cycle write/read of address 9
        step(1'b0, 1'b0, 1'b1, ADDR_W'(9), 32'h12345678, 1'b0, '0, '0, ADDR_W'(9), ADDR_W'(9));
        idle(ADDR_W'(9), ADDR_W'(5));

        // clear request, reset after 10 clear cycles, writes during clear are lost
        step(1'b0, 1'b1, 1'b1, ADDR_W'(20), 32'h0BADF00D, 1'b0, '0, '0, ADDR_W'(3), ADDR_W'(9));
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 1'b1, ADDR_W'(21), 32'hCAFE0000 + 32'(i), 1'b1, ADDR_W'(22), 32'h5555, ADDR_W'(20), ADDR_W'(21));
        step(1'b1, 1'b0, 1'b1, ADDR_W'(23), 32'h77777777, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b0, 1'b1, ADDR_W'(24), 32'h99999999, 1'b1, ADDR_W'(i), 32'h31415926, ADDR_W'(i), ADDR_W'(24));
        for (int i = 19; i < 26; i++) idle(ADDR_W'(i), ADDR_W'(3));

        // randomized traffic with a small address pool to provoke collisions and forwarding
        for (int n = 0; n < 2500; n++) begin
            a0 = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom());
            a1 = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom());
            ra = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom());
            rb = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom_range(0, 3)) : ADDR_W'($urandom());
            step(1'($urandom_range(0, 599) == 0), 1'($urandom_range(0, 199) == 0),
                 1'($urandom()), a0, DATA_W'($urandom()),
                 1'($urandom()), a1, DATA_W'($urandom()), ra, rb);
        end

        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised two-write/two-read register file for the MIPS CPU datapath, replacing the fixed 16-entry single-write register file. Adds a configurable width and depth, an optional hardwired-zero register 0, deterministic write-port priority, registered reads with optional write-to-read forwarding, and a sequential clear engine that zeroes the array one entry per cycle after reset or on request. Sits between the decode stage, which supplies read addresses, and writeback, which drives both write ports.

## Interface
- DATA_W, 32, data width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- clr_req  in  1  start a full-array clear (one-cycle pulse, honoured only when ready=1)
- ready  out  1  1 = array usable; 0 during clear
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- ra_a  in  ADDR_W  read address A
- ra_b  in  ADDR_W  read address B
- rd_a  out  DATA_W  registered read data A
- rd_b  out  DATA_W  registered read data B

## Operation
- States: CLEAR, RUN. Clear index clr_idx is ADDR_W bits wide.
- rst=1 at an edge: state<=CLEAR, clr_idx<=0, ready<=0, rd_a<=0, rd_b<=0. Array contents are not touched by rst itself; the clear engine zeroes them.
- CLEAR (rst=0): each edge writes mem[clr_idx]<=0 and increments clr_idx. At the edge where clr_idx==DEPTH-1: state<=RUN, ready<=1. we0/we1/clr_req are ignored, and rd_a/rd_b are held at 0.
- RUN: clr_req=1 at an edge: state<=CLEAR, clr_idx<=0, ready<=0. Writes and reads presented in that same cycle still complete normally.
- Writes in RUN: if weN=1, mem[waN]<=wdN. If wa0==wa1 and both are enabled, port 1 wins. With ZERO_REG=1, writes to address 0 are dropped.
- Reads in RUN: rd_a<=mem[ra_a] and rd_b<=mem[ra_b] each edge. With ZERO_REG=1, address 0 always returns 0.
- Forwarding (see Configuration): a same-cycle write to the read address supplies the read data, using the same port-1-over-port-0 priority. Address 0 with ZERO_REG=1 still returns 0.
- rst asserted mid-clear restarts the clear at index 0. rst has priority over clr_req.

## Timing
- Read latency: 1 cycle. Address at edge N gives data valid after edge N.
- Write visible to a non-forwarded read issued the following cycle (1-cycle write-to-read).
- Clear duration: DEPTH edges after the last rst edge. ready rises after edge DEPTH, e.g. 32 cycles for ADDR_W=5.
- Reset values: ready=0, rd_a=0, rd_b=0. Array is all zeros once ready=1.

## Configuration
- REGFILE_BYPASS_EN defined: a read whose address matches an enabled same-cycle write returns the new write data (port 1 first, then port 0, then the array).
- REGFILE_BYPASS_EN undefined: a same-cycle read returns the old array contents. Writeback must then stall or forward externally.

## Test plan
- Reset: rst high for 2 cycles, then low -> ready=0 for 32 cycles, rises after edge 32; every address reads 0; rd_a/rd_b stay 0 throughout.
- Dual write: we0 writes wa0=3, wd0=0x11111111 and we1 writes wa1=7, wd1=0x22222222 -> next cycle, ra_a=3 and ra_b=7 read 0x11111111 and 0x22222222.
- Collision: wa0=wa1=5 with wd0=0xAAAA0000 and wd1=0x0000BBBB -> address 5 reads 0x0000BBBB.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to address 0 on both ports -> rd_a at address 0 = 0. With ZERO_REG=0 it reads 0xFFFFFFFF.
- Forwarding: write 0x12345678 to address 9 while ra_a=9 in the same cycle -> rd_a=0x12345678 with REGFILE_BYPASS_EN, old value (0) without.
- Mid-clear reset: clr_req in RUN, then rst pulsed after 10 clear cycles -> clear restarts at index 0, ready rises 32 edges after rst drops, and writes attempted during clear are lost.
